rv32m_div_unit: RTL

Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the execute stage, directly upstream of the writeback-select 2:1 mux. That mux chooses between the ALU result and this unit's `result`. The unit accepts one operation at a time, iterates one quotient bit per clock, and returns a held result with a one-cycle `done` pulse.

---
 rtl/rv32m_pkg.sv | 20 ++
 rtl/div_abs_neg.sv | 13 +
 rtl/rv32m_div_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M iterative divider.
// Build option: RV32M_DIV_EARLY_OUT_EN (1-edge divide-by-zero/overflow).
package rv32m_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam int DIV_N       = 32;
  localparam int DIV_LATENCY = DIV_N + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } div_state_e;

endpackage

// File: rtl/div_abs_neg.sv
// Conditional two's-complement negate.
// Used for operand magnitudes and result sign correction.
module div_abs_neg #(
  parameter int n = 32
) (
  input  logic [n-1:0] a,
  input  logic         neg,
  output logic [n-1:0] y
);

  assign y = neg ? (~a + 1'b1) : a;

endmodule

// File: rtl/rv32m_div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Build option: RV32M_DIV_EARLY_OUT_EN skips CALC/FIX for special cases.
module rv32m_div_unit
  import rv32m_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         kill,
  input  logic [1:0]   op,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] result
);

  localparam int CW = $clog2(n);
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  div_state_e   state;
  logic [1:0]   op_q;
  logic [n-1:0] quo;
  logic [n-1:0] rem;
  logic [n-1:0] dvs_q;
  logic [n-1:0] dvd_q;
  logic [CW-1:0] cnt;
  logic         neg_q;
  logic         neg_r;
  logic         dz_q;

  logic         sgn;
  logic         dvd_neg;
  logic         dvs_neg;
  logic         dz_in;
  logic [n-1:0] dvd_abs;
  logic [n-1:0] dvs_abs;
  logic [n:0]   tmp;
  logic [n:0]   trial;
  logic         is_rem;
  logic [n-1:0] fix_val;
  logic         fix_neg;
  logic [n-1:0] fix_res;
  logic [n-1:0] final_res;

  assign sgn = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  assign dvd_neg = sgn & dividend[n-1];
  assign dvs_neg = sgn & divisor[n-1];
  assign dz_in = (divisor == '0);

  div_abs_neg #(.n(n)) u_dvd_abs (
    .a   (dividend),
    .neg (dvd_neg),
    .y   (dvd_abs)
  );

  div_abs_neg #(.n(n)) u_dvs_abs (
    .a   (divisor),
    .neg (dvs_neg),
    .y   (dvs_abs)
  );

  assign tmp = {rem, quo[n-1]};
  assign trial = tmp - {1'b0, dvs_q};

  assign is_rem = (op_q == DIV_OP_REM) || (op_q == DIV_OP_REMU);
  assign fix_val = is_rem ? rem : quo;
  assign fix_neg = is_rem ? neg_r : neg_q;

  div_abs_neg #(.n(n)) u_fix (
    .a   (fix_val),
    .neg (fix_neg),
    .y   (fix_res)
  );

  // Divide-by-zero bypasses the datapath entirely.
  assign final_res = !dz_q ? fix_res :
                     is_rem ? dvd_q : '1;

`ifdef RV32M_DIV_EARLY_OUT_EN
  logic ovf_in;
  assign ovf_in = sgn
    && (dividend == {1'b1, {(n-1){1'b0}}})
    && (divisor == '1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs_q  <= '0;
      dvd_q  <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz_q   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (kill) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              op_q  <= op;
              quo   <= dvd_abs;
              dvs_q <= dvs_abs;
              dvd_q <= dividend;
              rem   <= '0;
              cnt   <= '0;
              neg_q <= dvd_neg ^ dvs_neg;
              neg_r <= dvd_neg;
              dz_q  <= dz_in;
              busy  <= 1'b1;
              state <= S_CALC;
`ifdef RV32M_DIV_EARLY_OUT_EN
              // Overflow needs no iterations: quo=|dividend|, rem=0.
              if (dz_in || ovf_in) state <= S_DONE;
`endif
            end
          end
          S_CALC: begin
            if (!trial[n]) begin
              rem <= trial[n-1:0];
              quo <= {quo[n-2:0], 1'b1};
            end else begin
              rem <= tmp[n-1:0];
              quo <= {quo[n-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= S_FIX;
          end
          S_FIX: begin
            result <= final_res;
            state  <= S_DONE;
          end
          S_DONE: begin
            result <= final_res;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
